cnn_sdp_fifo: RTL

//  Parametrised synchronous FIFO built on a simple dual-port RAM (registered

---
 rtl/cnn_sdp_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cnn_sdp_fifo.sv
// Synchronous FIFO on a simple dual-port RAM with a registered read port.
// FWFT=1 adds one prefetched output register that is counted in the FIFO's total capacity.
module cnn_sdp_fifo #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int AFULL_TH  = 1020,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic wr_acc;
    logic rd_acc;
    logic fetch;

    // fetch moves one word from RAM into dout; ram_cnt excludes the word held in dout
    always_comb begin
        wr_acc = wr_en && !full_q && !clr;
        rd_acc = rd_en && !empty_q && !clr;
        if (FWFT != 0) begin
            fetch   = !clr && (ram_cnt_q != '0) && (!valid_q || rd_acc);
            valid_d = fetch ? 1'b1 : (rd_acc ? 1'b0 : valid_q);
        end else begin
            fetch   = rd_acc;
            valid_d = rd_acc;
        end

        wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = fetch  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        ram_cnt_d = ram_cnt_q + CNT_W'(wr_acc) - CNT_W'(fetch);

        full_d   = (count_d == DEPTH_C);
        empty_d  = (FWFT != 0) ? !valid_d : (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        ovf_d    = ovf_q | (wr_en && full_q);
        udf_d    = udf_q | (rd_en && empty_q);

        if (clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ram_cnt_d = '0;
            valid_d   = 1'b0;
            full_d    = 1'b0;
            empty_d   = 1'b1;
            afull_d   = 1'b0;
            aempty_d  = 1'b1;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ram_cnt_q <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ram_cnt_q <= ram_cnt_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage array has no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Registered read port; its output register carries the reset/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (clr) begin
            dout_q <= '0;
        end else if (fetch) begin
            dout_q <= mem[rd_ptr_q];
        end
    end

    assign dout         = dout_q;
    assign valid        = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
